// File: rtl/denise_colortable_ram_gen_if.sv
// Colour-table RAM bus: write port, read port, clock enable, read data and clear status.
// Latency: none (wires only).
// Backpressure: none; the enable line stalls the whole RAM instead.
interface denise_colortable_ram_gen_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              enable;
  logic              wren;
  logic [NB-1:0]     byteena;
  logic [ADDR_W-1:0] wraddress;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              busy;

  modport master (
    output enable, wren, byteena, wraddress, rdaddress, data,
    input  q, busy
  );

  modport slave (
    input  enable, wren, byteena, wraddress, rdaddress, data,
    output q, busy
  );
endinterface

// File: rtl/denise_colortable_ram_gen.sv
// Byte-enabled simple dual-port colour-table RAM with write-first bypass and post-reset clear.
// Latency: RD_STAGES enabled clock edges from rdaddress to q.
// Backpressure: none; enable low freezes memory, pipeline and clear sequencer.
module denise_colortable_ram_gen #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int RD_STAGES      = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                      clock,
  input logic                      reset_n,
  denise_colortable_ram_gen_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              clearing;

  logic              we;
  logic [NB-1:0]     wbe;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdat;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  logic [NB-1:0]     byp_be_q, byp_be_d;
  logic [DATA_W-1:0] byp_dat_q;
  logic              rd_zero_q;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] pipe_out;

  // FSM state and clear counter; both stall while enable is low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else if (bus.enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every address once, the counter MSB marks the end of the pass
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_d[ADDR_W]) state_d = ST_RUN;
    end
  end

  // FSM outputs: the clear sequencer owns the write port and drops external writes
  always_comb begin
    clearing = (state_q == ST_CLEAR);
    we       = bus.enable & (clearing | bus.wren);
    wbe      = clearing ? {NB{1'b1}} : bus.byteena;
    waddr    = clearing ? cnt_q[ADDR_W-1:0] : bus.wraddress;
    wdat     = clearing ? '0 : bus.data;
  end

  // Byte-enabled array with registered read; kept free of reset so it maps to block RAM
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
    if (bus.enable) ram_rd_q <= mem[bus.rdaddress];
  end

  // Lanes being written to the address being read this cycle come from the write data
  always_comb begin
    byp_be_d = '0;
    if (bus.wren && (bus.rdaddress == bus.wraddress)) byp_be_d = bus.byteena;
  end

  // Bypass lanes/data and the zero qualifier travel alongside the RAM read register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_be_q  <= '0;
      byp_dat_q <= '0;
      rd_zero_q <= 1'b1;
    end else if (bus.enable) begin
      byp_be_q  <= clearing ? '0 : byp_be_d;
      byp_dat_q <= bus.data;
      rd_zero_q <= clearing;
    end
  end

  // First-stage read data: per-lane merge of bypass and array output, zero while clearing
  always_comb begin
    rd1 = '0;
    if (!rd_zero_q) begin
      for (int i = 0; i < NB; i++) begin
        rd1[8*i +: 8] = byp_be_q[i] ? byp_dat_q[8*i +: 8] : ram_rd_q[8*i +: 8];
      end
    end
  end

  generate
    if (RD_STAGES == 2) begin : g_two_stage
      logic [DATA_W-1:0] rd2_q;
      // Optional second output register for timing
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        rd2_q <= '0;
        else if (bus.enable) rd2_q <= clearing ? '0 : rd1;
      end
      assign pipe_out = rd2_q;
    end else begin : g_one_stage
      assign pipe_out = rd1;
    end
  endgenerate

  assign bus.q    = clearing ? '0 : pipe_out;
  assign bus.busy = clearing;
endmodule

// File: doc/denise_colortable_ram_gen.md
Name: denise_colortable_ram_gen

Overview:
Parametrised, byte-enabled, simple dual-port colour-table RAM for Denise: one write port, one read port, one clock. It supersedes the fixed 256x32 table. Additions: generic width and depth, per-byte write-first bypass on same-address read/write, an optional second output register stage, and a hardware clear sequencer that zeroes the table after reset. It sits between the register-write path (COLORxx/bank writes) and the pixel-pipeline palette lookup.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W entries
DATA_W, 32, word width; must be a multiple of 8
NB, DATA_W/8, byte lanes (derived, not overridden)
RD_STAGES, 1, read latency in enabled cycles: 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every entry after reset release; 0 = no clear, busy stays 0

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  clock enable; all state, memory and pipeline advance only when high
wren  in  1  write request
byteena  in  NB  per-byte write mask; bit i covers data[8i+7:8i]
wraddress  in  ADDR_W  write address
rdaddress  in  ADDR_W  read address
data  in  DATA_W  write data
q  out  DATA_W  read data
busy  out  1  clear sequence in progress

Behaviour:
- Reset (reset_n low, async): q=0, busy=CLEAR_ON_RESET, clear counter=0, all pipeline registers=0; memory contents are not reset.
- FSM states: CLEAR, RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR: on each enabled cycle write all-zero, all bytes, to address cnt; cnt increments. After writing address 2**ADDR_W-1, go to RUN; busy falls on the same edge. Clear takes exactly 2**ADDR_W enabled cycles. Cycles with enable low do not advance it.
- During CLEAR: external wren is ignored and dropped, not queued. q is forced to 0 and the read pipeline loads 0.
- RUN write: when enable & wren, each byte i with byteena[i]=1 takes data byte i at wraddress. Bytes with mask 0 are unchanged. byteena=0 is a no-op.
- RUN read, RD_STAGES=1: q updates on the enabled edge after rdaddress is presented.
- RUN read, RD_STAGES=2: one extra enabled register stage; q is valid 2 enabled edges after the address.
- Read-during-write, same cycle, rdaddress==wraddress, wren=1: write-first, resolved per byte. Enabled bytes return the new data. Disabled bytes return the stored value. Different addresses do not interact.
- enable low: q, pipeline, FSM and memory all hold; writes are ignored.
- Reset asserted mid-CLEAR or mid-RUN: the clear restarts from address 0 on release. Any partial write in flight on the reset edge is lost.
- Address wrap: the counter is ADDR_W+1 bits wide, and its MSB ends the clear; there is no wrap into a second pass.
- Synthesis: the memory must infer block RAM with byte enables. The bypass mux and clear mux sit outside the array.

Test Plan:
- Reset then clear, ADDR_W=8, enable=1: busy is high for exactly 256 cycles. Reading addresses 0, 128 and 255 afterwards gives q=0x00000000, including after the memory was preloaded with 0xFFFFFFFF before reset.
- Byte-lane writes: write 0x11223344 with byteena=0xF to addr 5, then 0xAABBCCDD with byteena=0xA. Read addr 5 -> q=0xAA22CC44 after 1 cycle (RD_STAGES=1) and after 2 cycles (RD_STAGES=2).
- Same-address bypass: addr 9 holds 0x01020304. In one cycle write 0xF0F0F0F0 with byteena=0x3 and read addr 9 -> next q=0x0102F0F0. A different rdaddress returns its own stored word.
- Enable gating: hold enable low for 5 cycles mid-clear -> busy stays high 5 cycles longer. With enable low, a write to addr 3 is not stored and q does not change.
- Reset mid-clear: assert reset_n low at clear count 100 -> q=0 and busy=1 immediately. After release the clear takes a full 256 cycles. A write attempted during the clear to addr 20 (0x12345678) reads back 0.
- Parameter sweep: ADDR_W=4, DATA_W=16, CLEAR_ON_RESET=0 -> busy is 0 from reset. A write of 0xBEEF to addr 15, then a read of addr 15, gives 0xBEEF.
